// File: rtl/cypher_matcher.sv
// Scans a cypher word one digit per cycle, counting digits equal to a reference digit and
// accumulating a saturating sum; results are registered on completion.
module cypher_matcher #(
    parameter int unsigned DIGIT_W = 4,
    parameter int unsigned DIGITS  = 4,
    parameter int unsigned SUM_W   = 8
) (
    input  logic                             clock,
    input  logic                             reset_n,
    input  logic                             start,
    input  logic [DIGITS*DIGIT_W-1:0]        cypher,
    input  logic [DIGIT_W-1:0]               compared,
    input  logic                             mode,
    output logic                             busy,
    output logic                             done,
    output logic [SUM_W-1:0]                 sum_out,
    output logic [$clog2(DIGITS+1)-1:0]      match_count,
    output logic                             overflow
);

    localparam int unsigned IDX_W = $clog2(DIGITS);
    localparam int unsigned CNT_W = $clog2(DIGITS + 1);
    // One spare bit so the unclipped sum is always representable.
    localparam int unsigned ADD_W = ((SUM_W > DIGIT_W) ? SUM_W : DIGIT_W) + 1;
    localparam logic [ADD_W-1:0] SUM_MAX = ADD_W'({SUM_W{1'b1}});

    typedef enum logic [1:0] {StIdle, StScan, StDone} state_e;

    state_e                      state_q, state_d;
    logic [DIGITS*DIGIT_W-1:0]   cypher_q, cypher_d;
    logic [DIGIT_W-1:0]          compared_q, compared_d;
    logic                        mode_q, mode_d;
    logic [SUM_W-1:0]            acc_q, acc_d;
    logic [CNT_W-1:0]            cnt_q, cnt_d;
    logic                        sat_q, sat_d;
    logic [IDX_W-1:0]            idx_q, idx_d;
    logic [SUM_W-1:0]            sum_out_q, sum_out_d;
    logic [CNT_W-1:0]            match_q, match_d;
    logic                        ovf_q, ovf_d;

    logic [DIGIT_W-1:0]          digit;
    logic [ADD_W-1:0]            inc;
    logic [ADD_W-1:0]            sum_wide;
    logic                        clip;
    logic                        hit;
    logic                        last;

    assign digit    = cypher_q[DIGIT_W*idx_q +: DIGIT_W];
    assign inc      = mode_q ? ADD_W'(1) : ADD_W'(compared_q);
    assign sum_wide = ADD_W'(acc_q) + inc;
    assign clip     = sum_wide > SUM_MAX;
    assign hit      = digit == compared_q;
    assign last     = idx_q == IDX_W'(DIGITS - 1);

    always_comb begin
        state_d    = state_q;
        cypher_d   = cypher_q;
        compared_d = compared_q;
        mode_d     = mode_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        sat_d      = sat_q;
        idx_d      = idx_q;
        sum_out_d  = sum_out_q;
        match_d    = match_q;
        ovf_d      = ovf_q;
        case (state_q)
            StIdle: begin
                if (start) begin
                    cypher_d   = cypher;
                    compared_d = compared;
                    mode_d     = mode;
                    acc_d      = '0;
                    cnt_d      = '0;
                    sat_d      = 1'b0;
                    idx_d      = '0;
                    state_d    = StScan;
                end
            end
            StScan: begin
                if (hit) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    acc_d = clip ? {SUM_W{1'b1}} : sum_wide[SUM_W-1:0];
                    sat_d = sat_q | clip;
                end
                // Results include the final digit's contribution computed this cycle.
                if (last) begin
                    sum_out_d = acc_d;
                    match_d   = cnt_d;
                    ovf_d     = sat_d;
                    state_d   = StDone;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            cypher_q   <= '0;
            compared_q <= '0;
            mode_q     <= 1'b0;
            acc_q      <= '0;
            cnt_q      <= '0;
            sat_q      <= 1'b0;
            idx_q      <= '0;
            sum_out_q  <= '0;
            match_q    <= '0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cypher_q   <= cypher_d;
            compared_q <= compared_d;
            mode_q     <= mode_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            sat_q      <= sat_d;
            idx_q      <= idx_d;
            sum_out_q  <= sum_out_d;
            match_q    <= match_d;
            ovf_q      <= ovf_d;
        end
    end

    assign busy        = state_q != StIdle;
    assign done        = state_q == StDone;
    assign sum_out     = sum_out_q;
    assign match_count = match_q;
    assign overflow    = ovf_q;

endmodule

// File: tb/tb_cypher_matcher.sv
// Bench for cypher_matcher: three parameterisations driven together and checked against a
// digit-by-digit reference model.
module tb_cypher_matcher;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        start;
    logic        mode;
    logic [15:0] cyp16;
    logic [3:0]  cmp4;
    logic [14:0] cyp15;
    logic [2:0]  cmp3;

    logic       busy_a, done_a, ovf_a;
    logic [7:0] sum_a;
    logic [2:0] cnt_a;
    logic       busy_b, done_b, ovf_b;
    logic [4:0] sum_b;
    logic [2:0] cnt_b;
    logic       busy_c, done_c, ovf_c;
    logic [7:0] sum_c;
    logic [2:0] cnt_c;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    cypher_matcher dut_a (
        .clock(clock), .reset_n(reset_n), .start(start), .cypher(cyp16), .compared(cmp4),
        .mode(mode), .busy(busy_a), .done(done_a), .sum_out(sum_a), .match_count(cnt_a),
        .overflow(ovf_a)
    );

    cypher_matcher #(.SUM_W(5)) dut_b (
        .clock(clock), .reset_n(reset_n), .start(start), .cypher(cyp16), .compared(cmp4),
        .mode(mode), .busy(busy_b), .done(done_b), .sum_out(sum_b), .match_count(cnt_b),
        .overflow(ovf_b)
    );

    cypher_matcher #(.DIGITS(5), .DIGIT_W(3)) dut_c (
        .clock(clock), .reset_n(reset_n), .start(start), .cypher(cyp15), .compared(cmp3),
        .mode(mode), .busy(busy_c), .done(done_c), .sum_out(sum_c), .match_count(cnt_c),
        .overflow(ovf_c)
    );

    // Reference: walk the digits, saturating the running sum at 2^sw-1.
    function automatic void model(input logic [63:0] cyp, input int cmp, input bit md,
                                  input int digits, input int dw, input int sw,
                                  output int sum, output int cnt, output bit ovf);
        int maxv;
        int d;
        int inc;
        maxv = (1 << sw) - 1;
        sum = 0;
        cnt = 0;
        ovf = 1'b0;
        for (int i = 0; i < digits; i++) begin
            d = int'((cyp >> (i * dw)) & ((64'd1 << dw) - 64'd1));
            if (d == cmp) begin
                cnt++;
                inc = md ? 1 : cmp;
                if (sum + inc > maxv) begin
                    sum = maxv;
                    ovf = 1'b1;
                end else begin
                    sum = sum + inc;
                end
            end
        end
    endfunction

    // Called at a negedge; returns at a negedge with all instances idle.
    task automatic run_scan(input logic [15:0] c16, input logic [3:0] k4,
                            input logic [14:0] c15, input logic [2:0] k3,
                            input bit md, input bit scramble, input string tag);
        int ea_s, ea_c, eb_s, eb_c, ec_s, ec_c;
        bit ea_o, eb_o, ec_o;
        int lat_a, lat_b, lat_c, nd_a, nd_b, nd_c, nb_a, nb_c;
        model(64'(c16), int'(k4), md, 4, 4, 8, ea_s, ea_c, ea_o);
        model(64'(c16), int'(k4), md, 4, 4, 5, eb_s, eb_c, eb_o);
        model(64'(c15), int'(k3), md, 5, 3, 8, ec_s, ec_c, ec_o);
        lat_a = 0; lat_b = 0; lat_c = 0;
        nd_a = 0; nd_b = 0; nd_c = 0; nb_a = 0; nb_c = 0;
        cyp16 = c16; cmp4 = k4; cyp15 = c15; cmp3 = k3; mode = md; start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        if (scramble) begin
            cyp16 = 16'($urandom); cmp4 = 4'($urandom);
            cyp15 = 15'($urandom); cmp3 = 3'($urandom); mode = 1'($urandom);
        end
        for (int n = 1; n <= 10; n++) begin
            @(negedge clock);
            if (done_a) begin nd_a++; if (lat_a == 0) lat_a = n; end
            if (done_b) begin nd_b++; if (lat_b == 0) lat_b = n; end
            if (done_c) begin nd_c++; if (lat_c == 0) lat_c = n; end
            if (busy_a) nb_a++;
            if (busy_c) nb_c++;
            if (scramble && n == 2) start = 1'b1;
            if (n == 3) start = 1'b0;
        end
        checks++; if (lat_a !== 5) begin errors++;
            $display("FAIL %s latency_a: got %0d want 5", tag, lat_a); end
        checks++; if (lat_b !== 5) begin errors++;
            $display("FAIL %s latency_b: got %0d want 5", tag, lat_b); end
        checks++; if (lat_c !== 6) begin errors++;
            $display("FAIL %s latency_c: got %0d want 6", tag, lat_c); end
        checks++; if ({nd_a, nd_b, nd_c} !== {32'd1, 32'd1, 32'd1}) begin errors++;
            $display("FAIL %s done_pulses: got %0d/%0d/%0d want 1/1/1", tag, nd_a, nd_b, nd_c);
        end
        checks++; if ({nb_a, nb_c} !== {32'd5, 32'd6}) begin errors++;
            $display("FAIL %s busy_cycles: got %0d/%0d want 5/6", tag, nb_a, nb_c); end
        checks++; if ({sum_a, cnt_a, ovf_a} !== {8'(ea_s), 3'(ea_c), ea_o}) begin errors++;
            $display("FAIL %s result_a: got sum=%0d cnt=%0d ovf=%0d want %0d/%0d/%0d",
                     tag, sum_a, cnt_a, ovf_a, ea_s, ea_c, ea_o); end
        checks++; if ({sum_b, cnt_b, ovf_b} !== {5'(eb_s), 3'(eb_c), eb_o}) begin errors++;
            $display("FAIL %s result_b: got sum=%0d cnt=%0d ovf=%0d want %0d/%0d/%0d",
                     tag, sum_b, cnt_b, ovf_b, eb_s, eb_c, eb_o); end
        checks++; if ({sum_c, cnt_c, ovf_c} !== {8'(ec_s), 3'(ec_c), ec_o}) begin errors++;
            $display("FAIL %s result_c: got sum=%0d cnt=%0d ovf=%0d want %0d/%0d/%0d",
                     tag, sum_c, cnt_c, ovf_c, ec_s, ec_c, ec_o); end
    endtask

    task automatic check_all_zero(input string tag);
        checks++;
        if ({busy_a, done_a, sum_a, cnt_a, ovf_a, busy_b, done_b, sum_b, cnt_b, ovf_b,
             busy_c, done_c, sum_c, cnt_c, ovf_c} !== '0) begin
            errors++;
            $display("FAIL %s outputs_zero: got a=%0d/%0d/%0d/%0d/%0d b=%0d/%0d/%0d c=%0d/%0d/%0d want all 0",
                     tag, busy_a, done_a, sum_a, cnt_a, ovf_a, sum_b, cnt_b, ovf_b,
                     sum_c, cnt_c, ovf_c);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0; start = 1'b0; mode = 1'b0;
        cyp16 = '0; cmp4 = '0; cyp15 = '0; cmp3 = '0;
        #3;
        check_all_zero("reset_async");
        repeat (3) @(posedge clock);
        #1;
        check_all_zero("reset_held");
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    task automatic test_directed();
        run_scan(16'h3A33, 4'h3, 15'o77777, 3'd7, 1'b0, 1'b0, "basic");
        checks++; if ({sum_a, cnt_a, ovf_a} !== {8'd9, 3'd3, 1'b0}) begin errors++;
            $display("FAIL basic_const_a: got %0d/%0d/%0d want 9/3/0", sum_a, cnt_a, ovf_a); end
        checks++; if ({sum_c, cnt_c} !== {8'd35, 3'd5}) begin errors++;
            $display("FAIL basic_const_c: got %0d/%0d want 35/5", sum_c, cnt_c); end
        run_scan(16'hFFFF, 4'hF, 15'o00001, 3'd1, 1'b0, 1'b0, "saturate");
        checks++; if ({sum_b, cnt_b, ovf_b} !== {5'd31, 3'd4, 1'b1}) begin errors++;
            $display("FAIL sat_const_b: got %0d/%0d/%0d want 31/4/1", sum_b, cnt_b, ovf_b); end
        checks++; if ({sum_a, ovf_a} !== {8'd60, 1'b0}) begin errors++;
            $display("FAIL sat_const_a: got %0d/%0d want 60/0", sum_a, ovf_a); end
        run_scan(16'h0001, 4'h1, 15'o12345, 3'd3, 1'b0, 1'b0, "sat_clear");
        checks++; if ({sum_b, cnt_b, ovf_b} !== {5'd1, 3'd1, 1'b0}) begin errors++;
            $display("FAIL sat_clear_b: got %0d/%0d/%0d want 1/1/0", sum_b, cnt_b, ovf_b); end
    endtask

    task automatic test_back_to_back();
        int done_at[$];
        int e1_s, e1_c, e2_s, e2_c;
        bit e1_o, e2_o;
        model(64'h1234, 5, 1'b1, 4, 4, 8, e1_s, e1_c, e1_o);
        model(64'hFFFF, 15, 1'b1, 4, 4, 8, e2_s, e2_c, e2_o);
        cyp16 = 16'h1234; cmp4 = 4'h5; mode = 1'b1; start = 1'b1;
        @(posedge clock);
        #1;
        cyp16 = 16'hFFFF; cmp4 = 4'hF; mode = 1'b1;
        for (int n = 1; n <= 12; n++) begin
            @(negedge clock);
            if (done_a) done_at.push_back(n);
            if (n == 5 || n == 10) begin
                checks++; if ({sum_a, cnt_a, ovf_a} !== {8'(e1_s), 3'(e1_c), e1_o}) begin
                    errors++;
                    $display("FAIL b2b_first@%0d: got %0d/%0d/%0d want %0d/%0d/%0d",
                             n, sum_a, cnt_a, ovf_a, e1_s, e1_c, e1_o);
                end
            end
            if (n == 11) begin
                checks++; if ({sum_a, cnt_a, ovf_a} !== {8'(e2_s), 3'(e2_c), e2_o}) begin
                    errors++;
                    $display("FAIL b2b_second: got %0d/%0d/%0d want %0d/%0d/%0d",
                             sum_a, cnt_a, ovf_a, e2_s, e2_c, e2_o);
                end
                checks++; if ({sum_b, cnt_b} !== {5'd4, 3'd4}) begin errors++;
                    $display("FAIL b2b_second_b: got %0d/%0d want 4/4", sum_b, cnt_b); end
            end
            if (n == 12) start = 1'b0;
        end
        checks++;
        if (done_at.size() != 2 || done_at[0] != 5 || done_at[1] != 11) begin
            errors++;
            $display("FAIL b2b_done_times: got %0d pulses first=%0d want 2 pulses at 5,11",
                     done_at.size(), (done_at.size() > 0) ? done_at[0] : -1);
        end
        repeat (4) @(negedge clock);
    endtask

    task automatic test_reset_abort();
        int nd;
        nd = 0;
        cyp16 = 16'h7777; cmp4 = 4'h7; cyp15 = 15'o22222; cmp3 = 3'd2; mode = 1'b0;
        start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        @(negedge clock);
        cyp16 = 16'($urandom); start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        @(negedge clock);
        reset_n = 1'b0;
        #1;
        check_all_zero("abort_immediate");
        for (int n = 0; n < 8; n++) begin
            @(negedge clock);
            if (done_a || done_b || done_c) nd++;
            if (n == 0) reset_n = 1'b1;
        end
        checks++; if (nd !== 0) begin errors++;
            $display("FAIL abort_no_done: got %0d pulses want 0", nd); end
        check_all_zero("abort_no_update");
        reset_n = 1'b0;
        #2;
        reset_n = 1'b1;
        run_scan(16'h3A33, 4'h3, 15'o77777, 3'd7, 1'b0, 1'b0, "after_release");
    endtask

    task automatic test_random();
        logic [15:0] c16;
        logic [3:0]  k4;
        logic [14:0] c15;
        logic [2:0]  k3;
        for (int t = 0; t < 24; t++) begin
            k4 = 4'($urandom);
            k3 = 3'($urandom);
            for (int i = 0; i < 4; i++)
                c16[i*4 +: 4] = ($urandom_range(0, 1) == 1) ? k4 : 4'($urandom);
            for (int i = 0; i < 5; i++)
                c15[i*3 +: 3] = ($urandom_range(0, 1) == 1) ? k3 : 3'($urandom);
            run_scan(c16, k4, c15, k3, 1'($urandom), 1'b1, $sformatf("rand%0d", t));
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_reset_abort();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
